balanced_pipelined_adder: RTL
=============================

// Module: balanced_pipelined_adder
// PURPOSE
//   WIDTH-bit adder/subtractor built as a carry-pipelined ripple chain: one full-adder bit slice
//   per pipeline stage, with skew registers on the operands and de-skew registers on the sums.
//   All result bits leave the block in the same cycle.
//   Generalises the single-bit path-balanced full adder to N bits, with subtract mode and
//   valid tracking. One new operation is accepted every cycle.
//   Sits in datapaths where every path must be depth-balanced: ALU lanes and accumulator front-ends.
// PARAMETERS
//   WIDTH    8          operand/result width in bits; legal range 1..64
//   LATENCY  WIDTH      localparam, not overridable; cycles from input sample to output
// PORTS
//   clk        in   1      single clock; all state updates on its rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operands on a/b/cin/sub are valid this cycle
//   a          in   WIDTH  operand A (unsigned or two's-complement)
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in; ignored when sub=1
//   sub        in   1      0: a+b+cin   1: a-b (= a + ~b + 1)
//   out_valid  out  1      sum/cout/ovf hold a result this cycle
//   sum        out  WIDTH  result modulo 2^WIDTH
//   cout       out  1      carry out of the MSB; for sub it is NOT borrow (1 = a>=b unsigned)
//   ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset: async assert clears every pipeline register and every valid bit.
//     out_valid=0, sum=0, cout=0, ovf=0 while rst=1 and until the first result drains out.
//   - Sampling: a/b/cin/sub/in_valid are captured on every rising edge, whatever in_valid is.
//   - Latency: when in_valid=1 at edge n, out_valid=1 with that result after edge n+LATENCY.
//     out_valid is in_valid delayed by exactly LATENCY cycles.
//   - Throughput: one operation per cycle. No backpressure and no stall; the pipe always advances.
//   - Datapath stages:
//     - Bit k (0..WIDTH-1) is resolved in stage k. Its carry is registered into stage k+1.
//     - Operand bit k is delayed k cycles before it reaches its slice.
//     - Sum bit k is delayed (WIDTH-1-k) cycles after its slice.
//     - Final stage is the output register.
//   - Subtract: ~b and carry-in=1 are formed in stage 0; sub travels with the data.
//     Operations with different modes may be interleaved on consecutive cycles.
//   - Widths: internal carry is 1 bit per stage. ovf uses the carry into bit WIDTH-1.
//     For WIDTH=1 the carry into the MSB is the effective carry-in.
//   - Bubbles: when in_valid=0, the data lanes may carry arbitrary values.
//     Outputs during out_valid=0 are don't-care except after reset (0).
//   - Reset mid-operation: all in-flight operations are discarded with no partial output.
//     The first valid input after rst deasserts appears LATENCY cycles later.
//   - Wrap-around: sum is modulo 2^WIDTH; overflow is reported only through cout/ovf, never saturated.
// TESTING  (WIDTH=8 unless stated)
//   1. a=200, b=100, cin=0, sub=0 at edge n -> after edge n+8: out_valid=1, sum=44, cout=1, ovf=0.
//   2. a=5, b=7, sub=1 -> sum=0xFE, cout=0, ovf=0.
//      a=7, b=5, sub=1 -> sum=2, cout=1.
//   3. a=127, b=1, sub=0 -> sum=0x80, ovf=1, cout=0.
//      a=0x80, b=1, sub=1 -> sum=0x7F, ovf=1.
//   4. 16 back-to-back random ops with mixed sub and one in_valid=0 bubble.
//      -> 16 in-order results matching the reference model, with the bubble at the same relative cycle.
//   5. rst pulsed for 1 cycle while 4 ops are in flight -> no out_valid from them.
//      outputs=0; a new op issued right after deassert emerges 8 cycles later.
//   6. WIDTH=1 build: a=1, b=1, cin=1 -> after 1 cycle sum=1, cout=1.
//      WIDTH=32 build: 0xFFFFFFFF+1 -> sum=0, cout=1 after 32 cycles.

Source files
------------

// File: rtl/balanced_pipelined_adder_if.sv
// Operand and result bundle for balanced_pipelined_adder.
// The driver of operands uses the master modport and the adder uses the slave modport.
interface balanced_pipelined_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub,
    input  out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub,
    output out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/balanced_pipelined_adder.sv
// Carry-pipelined WIDTH-bit adder/subtractor: one full-adder slice per stage.
// Operands are skewed in and sums de-skewed out, so every result bit leaves in the same cycle.
module balanced_pipelined_adder #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  balanced_pipelined_adder_if.slave   bus
);
  localparam int LATENCY = WIDTH;

  logic [WIDTH-1:0]   w_b_in;
  logic               w_c0;
  logic [WIDTH-1:0]   w_a_st;
  logic [WIDTH-1:0]   w_b_st;
  logic [WIDTH-1:0]   w_s;
  logic [WIDTH-1:0]   w_co;
  logic [WIDTH-1:0]   w_sum_out;
  logic [WIDTH-1:0]   r_c;
  logic [LATENCY-1:0] r_v;
  logic               r_out_valid;
  logic               r_cout;
  logic               r_ovf;

  // Subtract is folded in on entry: ~b with a forced carry-in of 1, so cin is ignored.
  assign w_b_in = bus.b ^ {WIDTH{bus.sub}};
  assign w_c0   = bus.sub | bus.cin;

  // Bit k of the slice vectors sees operand bit k and the carry registered into stage k.
  assign w_s  = w_a_st ^ w_b_st ^ r_c;
  assign w_co = (w_a_st & w_b_st) | (r_c & (w_a_st ^ w_b_st));

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    localparam int DA = k + 1;
    localparam int DS = WIDTH - k;

    logic [DA-1:0] r_a_dly;
    logic [DA-1:0] r_b_dly;
    logic [DS-1:0] r_s_dly;

    // Operand skew: bit k is captured on entry and then delayed k more cycles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_a_dly <= {DA{1'b0}};
        r_b_dly <= {DA{1'b0}};
      end else begin
        r_a_dly <= (r_a_dly << 1'b1) | DA'(bus.a[k]);
        r_b_dly <= (r_b_dly << 1'b1) | DA'(w_b_in[k]);
      end
    end

    // Sum de-skew: the last register of each chain is the output register for that bit.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s_dly <= {DS{1'b0}};
      end else begin
        r_s_dly <= (r_s_dly << 1'b1) | DS'(w_s[k]);
      end
    end

    assign w_a_st[k]    = r_a_dly[DA-1];
    assign w_b_st[k]    = r_b_dly[DA-1];
    assign w_sum_out[k] = r_s_dly[DS-1];
  end

  // Carry pipeline: stage 0 takes the effective carry-in, stage k+1 the carry out of slice k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c <= {WIDTH{1'b0}};
    end else begin
      r_c <= (w_co << 1'b1) | WIDTH'(w_c0);
    end
  end

  // Valid tracking: in_valid travels alongside the data through every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= {LATENCY{1'b0}};
    end else begin
      r_v <= (r_v << 1'b1) | LATENCY'(bus.in_valid);
    end
  end

  // Output register for valid and flags; ovf compares the carries into and out of the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= r_v[LATENCY-1];
      r_cout      <= w_co[WIDTH-1];
      r_ovf       <= w_co[WIDTH-1] ^ r_c[WIDTH-1];
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.sum       = w_sum_out;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule
